// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-side register interface.
//   - ioaddr register-select codes
//   - TX launch state machine encoding
//   - bit positions inside the status register
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_t;

    localparam int ST_RDA    = 0;
    localparam int ST_TBR    = 1;
    localparam int ST_RXOVR  = 2;
    localparam int ST_TXOVF  = 3;
    localparam int ST_FERR   = 4;
    localparam int ST_TXIDLE = 5;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO used for both the SPART RX and TX buffers.
// Ports:
//   clk, rst    clock and synchronous active-high reset (pointers/count only)
//   push, wdata write request and data; ignored when full unless a pop
//               happens in the same cycle
//   pop         read request; ignored when empty
//   head        combinational view of the oldest entry
//   full, empty occupancy flags
//   count       number of stored entries (0..DEPTH)
module spart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a push into a full
        // FIFO is still accepted then.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/spart_bus_fifo.sv
// SPART processor-side register interface with RX/TX FIFOs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   iocs, iorw      chip select (one access per cycle) and 1=read/0=write
//   ioaddr          00 data, 01 status, 10 divisor low, 11 divisor high
//   databus         bidirectional bus, driven only during a read access
//   rx_valid        strobe from RX engine qualifying rx_data / rx_ferr
//   rx_data         received character
//   rx_ferr         framing error for the strobed character
//   tx_data         character handed to the TX engine
//   tx_start        one-cycle launch pulse to the TX engine
//   tx_busy         TX engine shifting
//   divisor_buffer  baud divisor to both engines
module spart_bus_fifo
    import spart_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          RX_DEPTH = 4,
    parameter int          TX_DEPTH = 4,
    parameter logic [15:0] DIV_RST  = 16'h0145
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iocs,
    input  logic                  iorw,
    input  logic [1:0]            ioaddr,
    inout  wire  [DATA_W-1:0]     databus,
    input  logic                  rx_valid,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_ferr,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic [2*DATA_W-1:0]   divisor_buffer
);

    localparam int                DIV_W    = 2 * DATA_W;
    localparam logic [DIV_W-1:0]  DIV_INIT = DIV_W'(DIV_RST);

    logic                         bus_rd, bus_wr;
    logic [DATA_W-1:0]            rd_data, status;

    logic                         rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0]            rx_head;
    logic [$clog2(RX_DEPTH):0]    rx_count;
    logic                         tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0]            tx_head;
    logic [$clog2(TX_DEPTH):0]    tx_count;

    logic                         rx_ovr_q, rx_ovr_d;
    logic                         tx_ovf_q, tx_ovf_d;
    logic                         ferr_q, ferr_d;
    logic [2:0]                   sticky_clr;

    logic [DIV_W-1:0]             div_q, div_d;
    tx_state_t                    state_q, state_d;
    logic [DATA_W-1:0]            tx_data_q, tx_data_d;

    // Occupancy counts are not needed at this level; flags suffice.
    logic                         unused_cnt;
    assign unused_cnt = ^{rx_count, tx_count};

    assign bus_rd = iocs && iorw;
    assign bus_wr = iocs && !iorw;

    assign databus        = (bus_rd && !rst) ? rd_data : 'z;
    assign tx_data        = tx_data_q;
    assign tx_start       = (state_q == TX_START);
    assign divisor_buffer = div_q;

    spart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    spart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (databus),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Status register and read mux
    always_comb begin
        status             = '0;
        status[ST_RDA]     = !rx_empty;
        status[ST_TBR]     = !tx_full;
        status[ST_RXOVR]   = rx_ovr_q;
        status[ST_TXOVF]   = tx_ovf_q;
        status[ST_FERR]    = ferr_q;
        status[ST_TXIDLE]  = tx_empty && (state_q == TX_IDLE);

        case (ioaddr)
            ADDR_DATA:   rd_data = rx_empty ? '0 : rx_head;
            ADDR_STATUS: rd_data = status;
            ADDR_DIV_LO: rd_data = div_q[DATA_W-1:0];
            default:     rd_data = div_q[DIV_W-1:DATA_W];
        endcase
    end

    // Bus side effects: FIFO requests, sticky flags, divisor
    always_comb begin
        rx_pop  = bus_rd && (ioaddr == ADDR_DATA) && !rx_empty;
        tx_push = bus_wr && (ioaddr == ADDR_DATA);

        sticky_clr = 3'b000;
        if (bus_rd && (ioaddr == ADDR_STATUS)) begin
            sticky_clr = 3'b111;
        end else if (bus_wr && (ioaddr == ADDR_STATUS)) begin
            sticky_clr = databus[ST_FERR:ST_RXOVR];
        end

        // Set terms are OR-ed after the clear so a set wins a collision.
        rx_ovr_d = (rx_ovr_q && !sticky_clr[0]) || (rx_valid && rx_full && !rx_pop);
        tx_ovf_d = (tx_ovf_q && !sticky_clr[1]) || (tx_push && tx_full && !tx_pop);
        ferr_d   = (ferr_q   && !sticky_clr[2]) || (rx_valid && rx_ferr);

        div_d = div_q;
        if (bus_wr && (ioaddr == ADDR_DIV_LO)) begin
            div_d[DATA_W-1:0] = databus;
        end
        if (bus_wr && (ioaddr == ADDR_DIV_HI)) begin
            div_d[DIV_W-1:DATA_W] = databus;
        end
    end

    // TX launch state machine
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_pop    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    tx_pop    = 1'b1;
                    tx_data_d = tx_head;
                    state_d   = TX_START;
                end
            end
            TX_START: state_d = TX_WAIT;
            TX_WAIT: begin
                // tx_busy is already high on the first TX_WAIT cycle.
                if (!tx_busy) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovr_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            ferr_q    <= 1'b0;
            div_q     <= DIV_INIT;
            state_q   <= TX_IDLE;
            tx_data_q <= '0;
        end else begin
            rx_ovr_q  <= rx_ovr_d;
            tx_ovf_q  <= tx_ovf_d;
            ferr_q    <= ferr_d;
            div_q     <= div_d;
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_spart_bus_fifo.sv
// Bench for spart_bus_fifo: queue-based reference model checked every cycle,
// directed register accesses with literal expectations, and a simple TX
// engine that stays busy for BUSY_LEN cycles after each tx_start.
module tb_spart_bus_fifo;

    localparam int          DATA_W   = 8;
    localparam int          RX_DEPTH = 4;
    localparam int          TX_DEPTH = 4;
    localparam int          BUSY_LEN = 10;
    localparam logic [15:0] DIV_RST  = 16'h0145;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              iocs = 1'b0;
    logic              iorw = 1'b0;
    logic [1:0]        ioaddr = 2'b00;
    logic              drv = 1'b0;
    logic [DATA_W-1:0] wdat = '0;
    wire  [DATA_W-1:0] databus;
    logic              rx_valid = 1'b0;
    logic              rx_ferr = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [2*DATA_W-1:0] divisor_buffer;

    logic              hold_busy = 1'b0;
    int                busy_cnt = 0;
    int                checks = 0;
    int                failures = 0;

    assign databus = drv ? wdat : 'z;
    always #5 clk = ~clk;

    spart_bus_fifo #(
        .DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .DIV_RST(DIV_RST)
    ) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ferr(rx_ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .divisor_buffer(divisor_buffer)
    );

    // TX engine stand-in
    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (tx_start)      busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = hold_busy || (busy_cnt != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model
    logic [DATA_W-1:0] rxq[$];
    logic [DATA_W-1:0] txq[$];
    bit                m_ovr, m_ovf, m_ferr;
    int                m_phase;     // 0 idle, 1 launch pulse, 2 waiting on engine
    logic [DATA_W-1:0] m_txd;
    logic [15:0]       m_div;
    bit                model_ok = 1'b0;

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s    = '0;
        s[0] = (rxq.size() != 0);
        s[1] = (txq.size() != TX_DEPTH);
        s[2] = m_ovr;
        s[3] = m_ovf;
        s[4] = m_ferr;
        s[5] = (txq.size() == 0) && (m_phase == 0);
        return s;
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return (rxq.size() != 0) ? rxq[0] : 8'h00;
            2'd1:    return m_status();
            2'd2:    return m_div[7:0];
            default: return m_div[15:8];
        endcase
    endfunction

    initial begin : model
        int       rsz, tsz;
        bit       rpop, tpop;
        bit [2:0] clr, set;
        forever begin
            @(posedge clk);
            if (rst) begin
                rxq.delete(); txq.delete();
                m_ovr = 0; m_ovf = 0; m_ferr = 0;
                m_phase = 0; m_txd = '0; m_div = DIV_RST;
                model_ok = 1'b1;
            end else begin
                rsz  = rxq.size();
                tsz  = txq.size();
                rpop = iocs && iorw && (ioaddr == 2'd0) && (rsz != 0);
                tpop = (m_phase == 0) && (tsz != 0) && !tx_busy;
                clr  = 3'b000;
                set  = 3'b000;
                if (iocs && iorw && ioaddr == 2'd1)  clr = 3'b111;
                if (iocs && !iorw && ioaddr == 2'd1) clr = wdat[4:2];
                if (rpop) void'(rxq.pop_front());
                if (rx_valid) begin
                    if (rsz == RX_DEPTH && !rpop) set[0] = 1'b1;
                    else rxq.push_back(rx_data);
                    if (rx_ferr) set[2] = 1'b1;
                end
                case (m_phase)
                    0: if (tpop) begin m_txd = txq.pop_front(); m_phase = 1; end
                    1: m_phase = 2;
                    default: if (!tx_busy) m_phase = 0;
                endcase
                if (iocs && !iorw && ioaddr == 2'd0) begin
                    if (tsz == TX_DEPTH && !tpop) set[1] = 1'b1;
                    else txq.push_back(wdat);
                end
                if (iocs && !iorw && ioaddr == 2'd2) m_div[7:0]  = wdat;
                if (iocs && !iorw && ioaddr == 2'd3) m_div[15:8] = wdat;
                m_ovr  = (m_ovr  && !clr[0]) || set[0];
                m_ovf  = (m_ovf  && !clr[1]) || set[1];
                m_ferr = (m_ferr && !clr[2]) || set[2];
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin : compare
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("tx_start", 32'(tx_start), 32'(m_phase == 1));
                chk("tx_data", 32'(tx_data), 32'(m_txd));
                chk("divisor", 32'(divisor_buffer), 32'(m_div));
                if (iocs && iorw && !rst)
                    chk("rd_data", 32'(databus), 32'(m_read(ioaddr)));
                else if (!drv)
                    chk("bus_hiz", 32'(databus === 'z), 32'(1));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            iocs = 0; drv = 0; rx_valid = 0; rx_ferr = 0;
            @(negedge clk);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        iocs = 1; iorw = 1; ioaddr = a; drv = 0; rx_valid = 0; rx_ferr = 0;
        @(negedge clk);
        d = databus;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        chk(name, 32'(d), 32'(exp));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        iocs = 1; iorw = 0; ioaddr = a; drv = 1; wdat = d; rx_valid = 0; rx_ferr = 0;
        @(negedge clk);
    endtask

    task automatic rx_push(input logic [7:0] d, input logic f);
        @(posedge clk); #1;
        iocs = 0; drv = 0; rx_valid = 1; rx_data = d; rx_ferr = f;
        @(negedge clk);
    endtask

    initial begin : stim
        logic [7:0] d;
        int         n;

        // Reset
        rst = 1;
        idle(2);
        chk("reset_hiz", 32'(databus === 'z), 32'(1));
        chk("reset_tx_start", 32'(tx_start), 32'(0));
        chk("reset_divisor", 32'(divisor_buffer), 32'(16'h0145));
        rst = 0;
        rd_chk("reset_status", 2'd1, 8'h22);
        rd_chk("reset_div_lo", 2'd2, 8'h45);
        rd_chk("reset_div_hi", 2'd3, 8'h01);

        // RX order and overrun
        for (int i = 0; i < 5; i++) rx_push(8'(8'hA1 + i), 1'b0);
        rd_chk("rx_ovr_status", 2'd1, 8'h27);
        for (int i = 0; i < 4; i++) rd_chk("rx_order", 2'd0, 8'(8'hA1 + i));
        rd_chk("rx_drained_status", 2'd1, 8'h22);

        // Push and pop together on a full RX FIFO
        for (int i = 0; i < 4; i++) rx_push(8'(8'hB1 + i), 1'b0);
        @(posedge clk); #1;
        iocs = 1; iorw = 1; ioaddr = 2'd0; drv = 0; rx_valid = 1; rx_data = 8'h55; rx_ferr = 0;
        @(negedge clk);
        chk("pushpop_head", 32'(databus), 32'(8'hB1));
        rd_chk("pushpop_status", 2'd1, 8'h23);
        rd_chk("pushpop_rd1", 2'd0, 8'hB2);
        rd_chk("pushpop_rd2", 2'd0, 8'hB3);
        rd_chk("pushpop_rd3", 2'd0, 8'hB4);
        rd_chk("pushpop_last", 2'd0, 8'h55);
        rd_chk("rx_empty_read", 2'd0, 8'h00);

        // TX launch latency
        bus_write(2'd0, 8'h3C);
        idle(1);
        chk("launch_w1", 32'(tx_start), 32'(0));
        idle(1);
        chk("launch_w2", 32'(tx_start), 32'(1));
        chk("launch_data", 32'(tx_data), 32'(8'h3C));
        idle(1);
        chk("launch_one_shot", 32'(tx_start), 32'(0));
        rd_chk("tx_busy_status", 2'd1, 8'h02);
        n = 0;
        while (tx_busy && n < 40) begin idle(1); n++; end
        chk("busy_falls", 32'(tx_busy), 32'(0));
        idle(1);
        rd_chk("tx_done_status", 2'd1, 8'h22);

        // TX overflow with engine held busy
        hold_busy = 1;
        for (int i = 0; i < 4; i++) bus_write(2'd0, 8'(8'h11 + i));
        rd_chk("tx_full_status", 2'd1, 8'h00);
        bus_write(2'd0, 8'h15);
        bus_write(2'd1, 8'h04);
        rd_chk("tx_ovf_kept", 2'd1, 8'h08);
        bus_write(2'd0, 8'h16);
        bus_write(2'd1, 8'h08);
        rd_chk("tx_ovf_w1c", 2'd1, 8'h00);
        hold_busy = 0;
        idle(70);
        rd_chk("tx_drain_status", 2'd1, 8'h22);

        // Framing error and divisor access
        rx_push(8'h7E, 1'b1);
        rd_chk("ferr_status", 2'd1, 8'h33);
        rd_chk("ferr_data", 2'd0, 8'h7E);
        bus_write(2'd2, 8'h9A);
        bus_write(2'd3, 8'h02);
        idle(1);
        chk("div_loaded", 32'(divisor_buffer), 32'(16'h029A));
        rd_chk("div_lo", 2'd2, 8'h9A);
        rd_chk("div_hi", 2'd3, 8'h02);

        // Reset in the middle of a transmit
        bus_write(2'd0, 8'h66);
        bus_write(2'd0, 8'h77);
        rx_push(8'h88, 1'b0);
        idle(3);
        chk("pre_rst_txdata", 32'(tx_data), 32'(8'h66));
        rst = 1;
        idle(1);
        chk("rst_tx_start", 32'(tx_start), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        rst = 0;
        rd_chk("rst_status", 2'd1, 8'h22);
        rd_chk("rst_rx_empty", 2'd0, 8'h00);
        rd_chk("rst_div_lo", 2'd2, 8'h45);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spart_bus_fifo.md
Name: spart_bus_fifo

Overview:
- Parametrised processor-side register interface for the SPART.
- Sits between the processor bus (iocs/iorw/ioaddr/databus) and the spart_rx/spart_tx baud engines.
- Replaces single-entry receive/transmit buffers with RX and TX FIFOs and adds sticky error flags, readable divisor and a TX launch state machine.
- Generalised in data width and FIFO depths.

Parameters:
DATA_W, 8, bus/character width; must be >= 8.
RX_DEPTH, 4, RX FIFO entries; power of 2, >= 2.
TX_DEPTH, 4, TX FIFO entries; power of 2, >= 2.
DIV_RST, 16'h0145, divisor reset value; truncated or zero-extended to 2*DATA_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
iocs  in  1  chip select; each cycle with iocs=1 is exactly one bus access
iorw  in  1  1=read, 0=write
ioaddr  in  2  register select: 00 data, 01 status, 10 divisor low, 11 divisor high
databus  inout  DATA_W  bidirectional processor data bus
rx_valid  in  1  one-cycle strobe from RX engine: rx_data holds a character
rx_data  in  DATA_W  received character
rx_ferr  in  1  framing error, qualified by rx_valid
tx_data  out  DATA_W  character to transmit, stable from tx_start until tx_busy falls
tx_start  out  1  one-cycle launch pulse to TX engine
tx_busy  in  1  TX engine shifting; rises the cycle after tx_start
divisor_buffer  out  2*DATA_W  baud divisor to both engines

Behaviour:
- Reset (clk edge with rst=1):
  - FIFOs emptied; all sticky flags cleared; TX FSM to TX_IDLE.
  - tx_start=0, tx_data=0, divisor_buffer=DIV_RST.
  - databus is high-Z during reset and whenever the bus is not reading.
- Databus drive: driven combinationally only while iocs && iorw; otherwise high-Z.
- Read mux (combinational, same cycle):
  - 00: RX FIFO head, or 0 if empty.
  - 01: status.
  - 10/11: divisor low/high half.
- Read side effects, at the end of the access cycle:
  - Read of 00 with RX non-empty pops the FIFO. A read of 00 on empty has no effect.
  - Read of 01 clears sticky bits 2-4.
- Writes:
  - 00: pushes databus into the TX FIFO. If TX is full, data is dropped and tx_ovf is set.
  - 01: W1C on sticky bits 2-4.
  - 10/11: load divisor low/high half. The new divisor drives divisor_buffer the next cycle.
- Status (bits above 5 read 0):
  - [0] rda = RX not empty.
  - [1] tbr = TX not full.
  - [2] rx_ovr sticky.
  - [3] tx_ovf sticky.
  - [4] ferr sticky.
  - [5] tx_idle = TX empty and FSM in TX_IDLE.
- RX push:
  - rx_valid pushes rx_data.
  - If RX is full, rx_data is dropped and rx_ovr is set.
  - rx_valid && rx_ferr sets ferr; the character is still pushed.
- Simultaneous events:
  - Push and pop in the same cycle on the same FIFO both happen and the count is unchanged. This holds when full, because the pop frees the slot, so no overrun.
  - Sticky set and clear in the same cycle: set wins.
- TX FSM, states TX_IDLE, TX_START, TX_WAIT:
  - TX_IDLE: if TX non-empty and !tx_busy, pop head into tx_data, then go to TX_START.
  - TX_START: tx_start=1 for exactly this cycle, then go to TX_WAIT.
  - TX_WAIT: hold until tx_busy=0 (tx_busy is high from the cycle after TX_START), then go to TX_IDLE.
  - Minimum spacing between tx_start pulses is 3 cycles plus the engine busy time.
- Latency:
  - A write to an empty TX FIFO with the engine idle produces tx_start 2 cycles after the write cycle.
  - rx_valid sets rda on the next cycle.
- Reset mid-operation: rst aborts any transmit handshake immediately (tx_start=0 next cycle) and discards FIFO contents. The engines are reset by the same rst.
- Width rules:
  - FIFO pointers are $clog2(DEPTH) bits and wrap naturally; counts are $clog2(DEPTH)+1 bits.
  - Full when count==DEPTH.

Decomposition:
- spart_pkg:
  - ioaddr constants ADDR_DATA/ADDR_STATUS/ADDR_DIV_LO/ADDR_DIV_HI.
  - tx_state_t enum.
  - Status bit index constants ST_RDA..ST_TXIDLE.
- One sub-module, spart_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated for RX and TX.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, then read 01 and read 10/11.
  - Expected: status=8'h22 (tbr, tx_idle); divisor reads 8'h45/8'h01; databus high-Z with iocs=0.
- RX FIFO order and overrun (DATA_W=8, RX_DEPTH=4):
  - Stimulus: rx_valid with 8'hA1..8'hA5 back-to-back, then read 01, read 00 four times, read 01 again.
  - Expected: first status shows rda and rx_ovr; data reads return A1,A2,A3,A4; second status shows rx_ovr=0 and rda=0.
- Simultaneous push/pop on full RX:
  - Stimulus: RX full; rx_valid=8'h55 in the same cycle as a read of 00.
  - Expected: head returned; count stays 4; no rx_ovr; 8'h55 is read last.
- TX launch:
  - Stimulus: write 8'h3C to 00 with the engine idle; model holds tx_busy high for 10 cycles.
  - Expected: tx_start pulses 2 cycles after the write with tx_data=8'h3C; tx_idle returns once tx_busy falls.
- TX overflow:
  - Stimulus: hold tx_busy=1; write 5 characters; then W1C 8'h08 to 01.
  - Expected: tbr=0 after the 4th write; 5th write sets tx_ovf; the W1C clears it.
- Framing error and mid-transmit reset:
  - Stimulus: rx_valid with rx_ferr=1 and data 8'h7E, then read 00.
  - Expected: ferr set and 8'h7E is read.
  - Stimulus: assert rst while in TX_WAIT.
  - Expected: FSM in TX_IDLE, FIFOs empty, status=8'h22 next cycle.
